// File: rtl/id_ex_skid_pkg.sv
// Shared widths, NOP encoding and skid-buffer state encodings for the ID/EX boundary.
package id_ex_skid_pkg;

  localparam int AluOpBus   = 8;
  localparam int AluSelBus  = 3;
  localparam int RegBus     = 32;
  localparam int RegAddrBus = 5;

  localparam logic [AluOpBus-1:0]   EXE_NOP_OP   = 8'h00;
  localparam logic [AluSelBus-1:0]  EXE_RES_NOP  = 3'b000;
  localparam logic [RegBus-1:0]     ZeroWord     = 32'h0000_0000;
  localparam logic [RegAddrBus-1:0] NOPRegAddr   = 5'b00000;
  localparam logic                  WriteDisable = 1'b0;

  typedef enum logic [1:0] {
    EMPTY = 2'b00,
    ONE   = 2'b01,
    FULL  = 2'b10
  } skid_state_e;

endpackage

// File: rtl/id_ex_skid_pipe_skid_buf.sv
// Generic W-bit two-entry skid buffer with valid/ready on both sides and synchronous flush.
// Ready is decoded from registered state only, so no combinational ready path crosses it.
module id_ex_skid_pipe_skid_buf
  import id_ex_skid_pkg::*;
#(
  parameter int             W       = 8,
  parameter logic [W-1:0]   NOP_VAL = '0
) (
  input  logic         clk_i,
  input  logic         rst_n_i,
  input  logic         flush_i,
  input  logic         in_valid_i,
  output logic         in_ready_o,
  input  logic [W-1:0] in_data_i,
  output logic         out_valid_o,
  input  logic         out_ready_i,
  output logic [W-1:0] out_data_o
);

  skid_state_e  state_q, state_d;
  logic [W-1:0] main_q, main_d;
  logic [W-1:0] skid_q, skid_d;
  logic         accept, drain;

  assign out_valid_o = (state_q != EMPTY);
  assign in_ready_o  = (state_q != FULL);
  assign out_data_o  = main_q;
  assign accept      = in_valid_i & in_ready_o;
  assign drain       = out_valid_o & out_ready_i;

  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    if (flush_i) begin
      // A drain in this cycle still completes downstream; an offered input is dropped.
      state_d = EMPTY;
      main_d  = NOP_VAL;
      skid_d  = NOP_VAL;
    end else begin
      case (state_q)
        EMPTY: begin
          if (accept) begin
            state_d = ONE;
            main_d  = in_data_i;
          end
        end
        ONE: begin
          if (accept && drain) begin
            main_d = in_data_i;
          end else if (accept) begin
            state_d = FULL;
            skid_d  = in_data_i;
          end else if (drain) begin
            state_d = EMPTY;
            main_d  = NOP_VAL;
          end
        end
        FULL: begin
          if (drain) begin
            state_d = ONE;
            main_d  = skid_q;
            skid_d  = NOP_VAL;
          end
        end
        default: begin
          state_d = EMPTY;
          main_d  = NOP_VAL;
          skid_d  = NOP_VAL;
        end
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q <= EMPTY;
      main_q  <= NOP_VAL;
      skid_q  <= NOP_VAL;
    end else begin
      state_q <= state_d;
      main_q  <= main_d;
      skid_q  <= skid_d;
    end
  end

endmodule

// File: rtl/id_ex_skid.sv
// ID->EX pipeline register built on a two-entry skid buffer, with flush, NOP forcing and an
// optional EX stall counter enabled by ID_EX_STALL_CNT_EN (port tied to zero otherwise).
module id_ex_skid
  import id_ex_skid_pkg::*;
#(
  parameter int ALUOP_W  = AluOpBus,
  parameter int ALUSEL_W = AluSelBus,
  parameter int REG_W    = RegBus,
  parameter int ADDR_W   = RegAddrBus
) (
  input  logic                Clk,
  input  logic                Rst_n,
  input  logic                flush,
  input  logic                id_valid,
  output logic                id_ready,
  input  logic [ALUOP_W-1:0]  id_aluop,
  input  logic [ALUSEL_W-1:0] id_alusel,
  input  logic [REG_W-1:0]    id_reg1,
  input  logic [REG_W-1:0]    id_reg2,
  input  logic [ADDR_W-1:0]   id_wd,
  input  logic                id_wreg,
  output logic                ex_valid,
  input  logic                ex_ready,
  output logic [ALUOP_W-1:0]  ex_aluop,
  output logic [ALUSEL_W-1:0] ex_alusel,
  output logic [REG_W-1:0]    ex_reg1,
  output logic [REG_W-1:0]    ex_reg2,
  output logic [ADDR_W-1:0]   ex_wd,
  output logic                ex_wreg,
  output logic [31:0]         stall_cnt
);

  localparam int BW = ALUOP_W + ALUSEL_W + 2 * REG_W + ADDR_W + 1;
  localparam logic [BW-1:0] NOP_BUNDLE = {ALUOP_W'(EXE_NOP_OP), ALUSEL_W'(EXE_RES_NOP),
                                          REG_W'(ZeroWord), REG_W'(ZeroWord),
                                          ADDR_W'(NOPRegAddr), WriteDisable};

  logic [BW-1:0] in_bundle, out_bundle;
  logic          out_valid;

  assign in_bundle = {id_aluop, id_alusel, id_reg1, id_reg2, id_wd, id_wreg};

  id_ex_skid_pipe_skid_buf #(
    .W       (BW),
    .NOP_VAL (NOP_BUNDLE)
  ) u_skid (
    .clk_i       (Clk),
    .rst_n_i     (Rst_n),
    .flush_i     (flush),
    .in_valid_i  (id_valid),
    .in_ready_o  (id_ready),
    .in_data_i   (in_bundle),
    .out_valid_o (out_valid),
    .out_ready_i (ex_ready),
    .out_data_o  (out_bundle)
  );

  // The buffer already parks NOP in empty slots; the mux keeps ex_wreg low when idle regardless.
  assign ex_valid = out_valid;
  assign {ex_aluop, ex_alusel, ex_reg1, ex_reg2, ex_wd, ex_wreg} =
    out_valid ? out_bundle : NOP_BUNDLE;

`ifdef ID_EX_STALL_CNT_EN
  logic [31:0] stall_cnt_q, stall_cnt_d;

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (ex_valid && !ex_ready && (stall_cnt_q != 32'hFFFF_FFFF))
      stall_cnt_d = stall_cnt_q + 32'd1;
  end

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) stall_cnt_q <= 32'd0;
    else        stall_cnt_q <= stall_cnt_d;
  end

  assign stall_cnt = stall_cnt_q;
`else
  assign stall_cnt = 32'd0;
`endif

endmodule

// File: tb/tb_id_ex_skid.sv
// Scoreboard bench for id_ex_skid: stimulus pushes expected bundles, a negedge monitor pops on drain.
module tb_id_ex_skid;

  logic        Clk = 1'b0;
  logic        Rst_n = 1'b1;
  logic        flush = 1'b0;
  logic        id_valid = 1'b0;
  logic        id_ready;
  logic [7:0]  id_aluop = '0;
  logic [2:0]  id_alusel = '0;
  logic [31:0] id_reg1 = '0;
  logic [31:0] id_reg2 = '0;
  logic [4:0]  id_wd = '0;
  logic        id_wreg = 1'b0;
  logic        ex_valid;
  logic        ex_ready = 1'b0;
  logic [7:0]  ex_aluop;
  logic [2:0]  ex_alusel;
  logic [31:0] ex_reg1;
  logic [31:0] ex_reg2;
  logic [4:0]  ex_wd;
  logic        ex_wreg;
  logic [31:0] stall_cnt;

  typedef logic [80:0] bundle_t;
  bundle_t sb[$];
  int n_checks = 0;
  int n_errors = 0;

  id_ex_skid dut (
    .Clk(Clk), .Rst_n(Rst_n), .flush(flush),
    .id_valid(id_valid), .id_ready(id_ready),
    .id_aluop(id_aluop), .id_alusel(id_alusel), .id_reg1(id_reg1), .id_reg2(id_reg2),
    .id_wd(id_wd), .id_wreg(id_wreg),
    .ex_valid(ex_valid), .ex_ready(ex_ready),
    .ex_aluop(ex_aluop), .ex_alusel(ex_alusel), .ex_reg1(ex_reg1), .ex_reg2(ex_reg2),
    .ex_wd(ex_wd), .ex_wreg(ex_wreg), .stall_cnt(stall_cnt)
  );

  always #5 Clk = ~Clk;

  task automatic chk(input string name, input logic [80:0] act, input logic [80:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic bundle_t ex_bundle();
    return {ex_aluop, ex_alusel, ex_reg1, ex_reg2, ex_wd, ex_wreg};
  endfunction

  // Drive one bundle; fields other than aluop/reg1 are fixed nonzero patterns so NOP is distinct.
  task automatic offer(input logic [7:0] op, input logic [31:0] r1, input bit expect_out);
    id_valid  = 1'b1;
    id_aluop  = op;
    id_alusel = 3'b101;
    id_reg1   = r1;
    id_reg2   = 32'h5A5A_0000;
    id_wd     = 5'h1F;
    id_wreg   = 1'b1;
    if (expect_out) sb.push_back({op, 3'b101, r1, 32'h5A5A_0000, 5'h1F, 1'b1});
  endtask

  task automatic idle_in();
    id_valid = 1'b0;
    id_aluop = '0; id_alusel = '0; id_reg1 = '0; id_reg2 = '0; id_wd = '0; id_wreg = 1'b0;
  endtask

  task automatic cyc();
    @(posedge Clk);
    #1;
  endtask

  always @(negedge Clk) begin
    if (Rst_n) begin
      if (ex_valid && ex_ready) begin
        if (sb.size() == 0) chk("unexpected_drain", ex_bundle(), '0);
        else                chk("drain_order", ex_bundle(), sb.pop_front());
      end else if (!ex_valid) begin
        chk("idle_is_nop", ex_bundle(), '0);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    n_errors++;
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $fatal(1, "watchdog");
  end

  localparam logic [31:0] STALL_EXP =
`ifdef ID_EX_STALL_CNT_EN
    32'd5;
`else
    32'd0;
`endif

  initial begin
    #2 Rst_n = 1'b0;
    #1;
    chk("rst_ex_valid", 81'(ex_valid), 81'(0));
    chk("rst_id_ready", 81'(id_ready), 81'(1));
    chk("rst_bundle", ex_bundle(), '0);
    chk("rst_stall_cnt", 81'(stall_cnt), 81'(0));
    #8 Rst_n = 1'b1;
    cyc();

    // Streaming with a one-cycle bubble
    ex_ready = 1'b1;
    offer(8'h21, 32'h1, 1'b1); cyc();
    chk("stream_lat1", 81'(ex_aluop), 81'(8'h21));
    chk("stream_rdy1", 81'(id_ready), 81'(1));
    offer(8'h22, 32'h2, 1'b1); cyc();
    chk("stream_2", 81'(ex_aluop), 81'(8'h22));
    offer(8'h23, 32'h3, 1'b1); cyc();
    chk("stream_3", 81'(ex_aluop), 81'(8'h23));
    chk("stream_rdy3", 81'(id_ready), 81'(1));
    idle_in(); cyc();
    chk("bubble_valid", 81'(ex_valid), 81'(0));
    chk("bubble_wd_wreg", 81'({ex_wd, ex_wreg}), 81'(0));
    offer(8'h24, 32'h4, 1'b1); cyc();
    chk("after_bubble", 81'({ex_valid, ex_aluop}), 81'({1'b1, 8'h24}));
    idle_in(); cyc();

    // Backpressure: two bundles fill the buffer, then drain in order
    ex_ready = 1'b0;
    offer(8'h30, 32'hA, 1'b1); cyc();
    chk("bp_rdy_one", 81'(id_ready), 81'(1));
    offer(8'h31, 32'hB, 1'b1); cyc();
    chk("bp_rdy_full", 81'(id_ready), 81'(0));
    chk("bp_hold_a", 81'(ex_reg1), 81'(32'hA));
    idle_in(); cyc();
    chk("bp_still_a", 81'(ex_reg1), 81'(32'hA));
    ex_ready = 1'b1; cyc();
    chk("bp_then_b", 81'(ex_reg1), 81'(32'hB));
    chk("bp_rdy_back", 81'(id_ready), 81'(1));
    cyc();
    chk("bp_empty", 81'(ex_valid), 81'(0));

    // Flush while FULL with a new bundle offered
    ex_ready = 1'b0;
    offer(8'h40, 32'h1, 1'b0); cyc();
    offer(8'h41, 32'h2, 1'b0); cyc();
    offer(8'h42, 32'hC, 1'b0); flush = 1'b1; cyc();
    flush = 1'b0; idle_in();
    chk("flush_full_valid", 81'(ex_valid), 81'(0));
    chk("flush_full_nop", ex_bundle(), '0);
    chk("flush_full_rdy", 81'(id_ready), 81'(1));
    ex_ready = 1'b1; cyc(); cyc();
    chk("flush_no_c", 81'(ex_valid), 81'(0));

    // Flush in ONE drops an input even though id_ready is high
    ex_ready = 1'b0;
    offer(8'h50, 32'hD, 1'b0); cyc();
    offer(8'h51, 32'hE, 1'b0); flush = 1'b1; cyc();
    flush = 1'b0; idle_in();
    chk("flush_one_drop", 81'(ex_valid), 81'(0));

    // Flush with simultaneous drain: EX keeps that bundle
    ex_ready = 1'b1;
    offer(8'h60, 32'hF, 1'b1); cyc();
    idle_in(); flush = 1'b1; cyc();
    flush = 1'b0;
    chk("flush_drain_empty", 81'(ex_valid), 81'(0));

    // Asynchronous reset while FULL
    ex_ready = 1'b0;
    offer(8'h70, 32'h7, 1'b0); cyc();
    offer(8'h71, 32'h8, 1'b0); cyc();
    idle_in();
    chk("pre_rst_full", 81'(id_ready), 81'(0));
    #2 Rst_n = 1'b0;
    #1;
    chk("midrst_valid", 81'(ex_valid), 81'(0));
    chk("midrst_rdy", 81'(id_ready), 81'(1));
    chk("midrst_aluop_wreg", 81'({ex_aluop, ex_wreg}), 81'(0));
    chk("midrst_stall", 81'(stall_cnt), 81'(0));
    #3 Rst_n = 1'b1;
    cyc();

    // Stall counter: five stalled cycles, then flush alongside a drain
    offer(8'h80, 32'h80, 1'b1); cyc();
    idle_in();
    for (int i = 0; i < 5; i++) cyc();
    chk("stall_cnt_5", 81'(stall_cnt), 81'(STALL_EXP));
    ex_ready = 1'b1; flush = 1'b1; cyc();
    flush = 1'b0; cyc();
    chk("stall_cnt_after_flush", 81'(stall_cnt), 81'(STALL_EXP));
    cyc();

    chk("scoreboard_empty", 81'(sb.size()), 81'(0));
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
